// File: rtl/irq_sync_stretcher.sv
// irq_sync_stretcher
//   Conditions raw interrupt lines from FPGA-side IP before they reach the
//   peripherals wrapper irq_i[NumSources-1:7] input (bit 0 -> irq_i[7]).
//   Every line is synchronized into aclk. Level lines are passed through as
//   registered levels. Edge lines turn each 0->1 transition into a level pulse
//   exactly STRETCH cycles wide, so the PLIC gateway is sure to sample it.
//
// Parameters
//   NUM_IRQ      number of lines (normally ariane_soc::NumSources-7)
//   SYNC_STAGES  synchronizer depth per line, 2..4
//   EDGE_MASK    bit i = 1 -> line i is rising-edge type, 0 -> level type
//   STRETCH      edge-line output pulse width in aclk cycles, 1..255
//
// Ports
//   aclk         clock
//   aresetn      asynchronous active-low reset, clears every flop
//   irq_async_i  raw interrupt lines, asynchronous to aclk
//   irq_o        conditioned, registered interrupts
//   overrun_o    one-cycle pulse: a new edge arrived while the line was
//                still stretching (always 0 on level lines)
module irq_sync_stretcher #(
  parameter int                 NUM_IRQ     = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
  parameter int                 STRETCH     = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NUM_IRQ-1:0] irq_async_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic [NUM_IRQ-1:0] overrun_o
);

  localparam int                CNT_W     = $clog2(STRETCH + 1);
  localparam logic [CNT_W-1:0] STRETCH_C = CNT_W'(STRETCH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Synchronizer: plain flop chain, no logic between stages
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0]                  s;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_async_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-line conditioning stage
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
    if (EDGE_MASK[gi]) begin : g_edge
      logic             prev_q;
      logic             rise;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             irq_q, irq_d;
      logic             ovr_q, ovr_d;

      assign rise = s[gi] & ~prev_q;

      // A rise always reloads the full width; a rise while the counter is
      // still running extends the pulse and is flagged as an overrun.
      always_comb begin
        cnt_d = cnt_q;
        irq_d = irq_q;
        ovr_d = 1'b0;
        if (rise) begin
          cnt_d = STRETCH_C;
          irq_d = 1'b1;
          ovr_d = (cnt_q != '0);
        end else if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (cnt_q == CNT_ONE) begin
          cnt_d = '0;
          irq_d = 1'b0;
        end
      end

      // prev clears on reset, so an input still high after release is seen
      // as a fresh rise and no interrupt is lost across reset.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          prev_q <= 1'b0;
          cnt_q  <= '0;
          irq_q  <= 1'b0;
          ovr_q  <= 1'b0;
        end else begin
          prev_q <= s[gi];
          cnt_q  <= cnt_d;
          irq_q  <= irq_d;
          ovr_q  <= ovr_d;
        end
      end

      assign irq_o[gi]     = irq_q;
      assign overrun_o[gi] = ovr_q;
    end else begin : g_level
      logic irq_q;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          irq_q <= 1'b0;
        end else begin
          irq_q <= s[gi];
        end
      end

      assign irq_o[gi]     = irq_q;
      assign overrun_o[gi] = 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_sync_stretcher.sv
// Bench for irq_sync_stretcher.
//   dut  : 8 lines, mask 0xA5 (lines 0,2,5,7 edge; 1,3,4,6 level), STRETCH 16
//   dut1 : 1 edge line, STRETCH 1
// Each cycle index c: inputs are set after the previous sample, edge c
// happens, outputs are sampled #1 later. An input set at c is captured by
// edge c, reaches the last sync stage at c+1 and irq_o at c+2.
module tb_irq_sync_stretcher;

  logic       aclk;
  logic       aresetn;
  logic [7:0] irq_async;
  logic [7:0] irq_o;
  logic [7:0] ovr_o;
  logic [0:0] irq1_async;
  logic [0:0] irq1_o;
  logic [0:0] ovr1_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] irq;
    logic [7:0] ovr;
    logic       irq1;
    logic       ovr1;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [7:0] EDGE_M = 8'hA5;
  localparam logic [7:0] LVL_M  = 8'h5A;

  irq_sync_stretcher #(
    .NUM_IRQ(8), .SYNC_STAGES(2), .EDGE_MASK(EDGE_M), .STRETCH(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .irq_async_i(irq_async),
    .irq_o(irq_o), .overrun_o(ovr_o)
  );

  irq_sync_stretcher #(
    .NUM_IRQ(1), .SYNC_STAGES(2), .EDGE_MASK(1'b1), .STRETCH(1)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn), .irq_async_i(irq1_async),
    .irq_o(irq1_o), .overrun_o(ovr1_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic test_reset();
    exp_t got;
    aresetn    = 1'b0;
    irq_async  = '0;
    irq1_async = '0;
    repeat (3) @(posedge aclk);
    #1;
    got = {irq_o, ovr_o, irq1_o, ovr1_o};
    checks++;
    if (got !== exp_t'(0)) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", got, exp_t'(0));
    end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Line 1 is a level line: follows the input two sample points later.
  task automatic test_level();
    exp_t e, got;
    for (int c = 0; c < 20; c++) begin
      irq_async    = '0;
      irq_async[1] = (c >= 2 && c < 12);
      e = {(c >= 4 && c < 14) ? 8'h02 : 8'h00, 8'h00, 1'b0, 1'b0};
      sb_q.push_back(e);
      @(posedge aclk); #1;
      e   = sb_q.pop_front();
      got = {irq_o, ovr_o, irq1_o, ovr1_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL level c=%0d: got %h required %h", c, got, e);
      end
    end
  endtask

  // Line 0 is an edge line: 1-cycle and 40-cycle inputs give the same
  // 16-cycle pulse.
  task automatic test_edge_stretch();
    exp_t e, got;
    for (int w = 0; w < 2; w++) begin
      int width;
      width = (w == 0) ? 1 : 40;
      for (int c = 0; c < 48; c++) begin
        irq_async    = '0;
        irq_async[0] = (c >= 2 && c < 2 + width);
        e = {(c >= 4 && c < 20) ? 8'h01 : 8'h00, 8'h00, 1'b0, 1'b0};
        sb_q.push_back(e);
        @(posedge aclk); #1;
        e   = sb_q.pop_front();
        got = {irq_o, ovr_o, irq1_o, ovr1_o};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL edge_w%0d c=%0d: got %h required %h", width, c, got, e);
        end
      end
    end
  endtask

  // Second edge 10 cycles into the pulse: overrun for one cycle, pulse
  // extends to 26 cycles total.
  task automatic test_retrigger();
    exp_t e, got;
    for (int c = 0; c < 36; c++) begin
      irq_async    = '0;
      irq_async[0] = (c == 2) || (c == 12);
      e = {(c >= 4 && c < 30) ? 8'h01 : 8'h00, (c == 14) ? 8'h01 : 8'h00, 1'b0, 1'b0};
      sb_q.push_back(e);
      @(posedge aclk); #1;
      e   = sb_q.pop_front();
      got = {irq_o, ovr_o, irq1_o, ovr1_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL retrigger c=%0d: got %h required %h", c, got, e);
      end
    end
  endtask

  // Reset asserted at pulse cycle 5 with input still high; one fresh pulse
  // follows release.
  task automatic test_reset_mid();
    exp_t e, got;
    for (int c = 0; c < 9; c++) begin
      irq_async    = '0;
      irq_async[0] = (c >= 2);
      e = {(c >= 4) ? 8'h01 : 8'h00, 8'h00, 1'b0, 1'b0};
      sb_q.push_back(e);
      @(posedge aclk); #1;
      e   = sb_q.pop_front();
      got = {irq_o, ovr_o, irq1_o, ovr1_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_pre c=%0d: got %h required %h", c, got, e);
      end
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (irq_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_async: got irq %h required 00", irq_o);
    end
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({irq_o, ovr_o} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_hold: got %h required 0000", {irq_o, ovr_o});
    end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 24; c++) begin
      irq_async    = '0;
      irq_async[0] = (c < 20);
      e = {(c >= 2 && c < 18) ? 8'h01 : 8'h00, 8'h00, 1'b0, 1'b0};
      sb_q.push_back(e);
      @(posedge aclk); #1;
      e   = sb_q.pop_front();
      got = {irq_o, ovr_o, irq1_o, ovr1_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_post c=%0d: got %h required %h", c, got, e);
      end
    end
  endtask

  // STRETCH 1: pulses 1,0,1 on the input give 1,0,1 on the output, no overrun.
  task automatic test_back_to_back();
    exp_t e, got;
    for (int c = 0; c < 10; c++) begin
      irq_async  = '0;
      irq1_async = ((c == 2) || (c == 4)) ? 1'b1 : 1'b0;
      e = {8'h00, 8'h00, (c == 4) || (c == 6), 1'b0};
      sb_q.push_back(e);
      @(posedge aclk); #1;
      e   = sb_q.pop_front();
      got = {irq_o, ovr_o, irq1_o, ovr1_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back c=%0d: got %h required %h", c, got, e);
      end
    end
  endtask

  // All eight lines rise together for 8 cycles: level lines follow for 8,
  // edge lines stretch to 16.
  task automatic test_mixed_mask();
    exp_t e, got;
    logic [7:0] lv, ed;
    for (int c = 0; c < 26; c++) begin
      irq_async  = (c >= 2 && c < 10) ? 8'hFF : 8'h00;
      irq1_async = 1'b0;
      lv = (c >= 4 && c < 12) ? LVL_M : 8'h00;
      ed = (c >= 4 && c < 20) ? EDGE_M : 8'h00;
      e  = {lv | ed, 8'h00, 1'b0, 1'b0};
      sb_q.push_back(e);
      @(posedge aclk); #1;
      e   = sb_q.pop_front();
      got = {irq_o, ovr_o, irq1_o, ovr1_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mixed_mask c=%0d: got %h required %h", c, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_stretch();
    test_retrigger();
    test_reset_mid();
    test_back_to_back();
    test_mixed_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
